// File: rtl/gpio_cond_pkg.sv
// Shared types and default parameters for the GPIO input conditioner.
package gpio_cond_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned FILTER_CYCLES_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } cond_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
module sync_ff_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronises and glitch-filters the ESP32 GPIO1 input; publishes a clean
// level, edge strobes and accepted-edge / rejected-glitch counters.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gpio_in,
  input  logic                 cnt_clr,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic          s;
  cond_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rise_c, fall_c, glitch_c;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (gpio_in),
    .q  (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new level must be seen for FILTER_CYCLES consecutive samples; the first
  // sample is the one that leaves the stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_c    = 1'b0;
    fall_c    = 1'b0;
    glitch_c  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          if (FILTER_CYCLES == 1) begin
            state_nxt = STABLE_HIGH;
            rise_c    = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = PEND_HIGH;
            cnt_nxt   = CW'(1);
          end
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_nxt = STABLE_LOW;
          glitch_c  = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
          state_nxt = STABLE_HIGH;
          rise_c    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          if (FILTER_CYCLES == 1) begin
            state_nxt = STABLE_LOW;
            fall_c    = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = PEND_LOW;
            cnt_nxt   = CW'(1);
          end
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_nxt = STABLE_HIGH;
          glitch_c  = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
          state_nxt = STABLE_LOW;
          fall_c    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (rise_c) begin
        level_out <= 1'b1;
      end else if (fall_c) begin
        level_out <= 1'b0;
      end
      rise_pulse <= rise_c;
      fall_pulse <= fall_c;
    end
  end

  // Edge counter wraps; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      edge_count <= '0;
    end else if (rise_c || fall_c) begin
      edge_count <= edge_count + CNT_WIDTH'(1);
    end
  end

  // Glitch counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      glitch_count <= '0;
    end else if (glitch_c && (glitch_count != '1)) begin
      glitch_count <= glitch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench: default instance (table + sequences), a narrow-counter
// instance for wrap/saturation, and a FILTER_CYCLES=1 instance for latency.
module tb_gpio_in_conditioner;

  logic clk = 1'b0;
  logic rst;

  logic        gpio0, clr0, level0, rise0, fall0;
  logic [15:0] edge0, glitch0;
  logic        gpio1, clr1, level1, rise1, fall1;
  logic [3:0]  edge1, glitch1;
  logic        gpio2, clr2, level2, rise2, fall2;
  logic [15:0] edge2, glitch2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_in_conditioner u_dut0 (
    .clk(clk), .rst(rst), .gpio_in(gpio0), .cnt_clr(clr0),
    .level_out(level0), .rise_pulse(rise0), .fall_pulse(fall0),
    .edge_count(edge0), .glitch_count(glitch0)
  );

  gpio_in_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .gpio_in(gpio1), .cnt_clr(clr1),
    .level_out(level1), .rise_pulse(rise1), .fall_pulse(fall1),
    .edge_count(edge1), .glitch_count(glitch1)
  );

  gpio_in_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(1), .CNT_WIDTH(16)
  ) u_dut2 (
    .clk(clk), .rst(rst), .gpio_in(gpio2), .cnt_clr(clr2),
    .level_out(level2), .rise_pulse(rise2), .fall_pulse(fall2),
    .edge_count(edge2), .glitch_count(glitch2)
  );

  typedef struct {
    logic        gpio;
    int unsigned hold;
    logic        clr;
    logic        exp_level;
    logic [15:0] exp_edge;
    logic [15:0] exp_glitch;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Starting point for the table: dut0 stable high, edge=1, glitch=0.
    vecs[0] = '{1'b0,  5, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 30, 1'b0, 1'b1, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 15, 1'b0, 1'b1, 16'd1, 16'd1};
    vecs[3] = '{1'b1, 30, 1'b0, 1'b1, 16'd1, 16'd2};
    vecs[4] = '{1'b0, 16, 1'b0, 1'b1, 16'd1, 16'd2};
    vecs[5] = '{1'b1, 30, 1'b0, 1'b1, 16'd3, 16'd2};
    vecs[6] = '{1'b1,  3, 1'b1, 1'b1, 16'd0, 16'd0};
    vecs[7] = '{1'b0, 40, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[8] = '{1'b1, 15, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[9] = '{1'b0, 20, 1'b0, 1'b0, 16'd1, 16'd1};

    rst = 1'b1;
    gpio0 = 1'b0; clr0 = 1'b0;
    gpio1 = 1'b0; clr1 = 1'b0;
    gpio2 = 1'b0; clr2 = 1'b0;
    tick(3);
    check("rst_level",  32'(level0),  32'd0);
    check("rst_rise",   32'(rise0),   32'd0);
    check("rst_fall",   32'(fall0),   32'd0);
    check("rst_edge",   32'(edge0),   32'd0);
    check("rst_glitch", 32'(glitch0), 32'd0);

    // Input already high as reset releases; next edge is edge 0.
    rst = 1'b0;
    gpio0 = 1'b1;
    gpio2 = 1'b1;
    tick(2);
    check("f1_level_before", 32'(level2), 32'd0);
    tick(1);
    check("f1_level_rise", 32'(level2), 32'd1);
    check("f1_rise_pulse", 32'(rise2),  32'd1);
    gpio2 = 1'b0;
    tick(2);
    check("f1_level_hold", 32'(level2), 32'd1);
    tick(1);
    check("f1_level_fall", 32'(level2), 32'd0);
    check("f1_fall_pulse", 32'(fall2),  32'd1);
    check("f1_edge",       32'(edge2),  32'd2);

    tick(11);
    check("lat_level_e16", 32'(level0), 32'd0);
    check("lat_rise_e16",  32'(rise0),  32'd0);
    tick(1);
    check("lat_level_e17", 32'(level0), 32'd1);
    check("lat_rise_e17",  32'(rise0),  32'd1);
    check("lat_fall_e17",  32'(fall0),  32'd0);
    tick(1);
    check("lat_rise_off", 32'(rise0),   32'd0);
    check("lat_edge",     32'(edge0),   32'd1);
    check("lat_glitch",   32'(glitch0), 32'd0);

    for (int i = 0; i < 10; i++) begin
      gpio0 = vecs[i].gpio;
      clr0  = vecs[i].clr;
      tick(vecs[i].hold);
      check($sformatf("vec%0d_level", i),  32'(level0),  32'(vecs[i].exp_level));
      check($sformatf("vec%0d_edge", i),   32'(edge0),   32'(vecs[i].exp_edge));
      check($sformatf("vec%0d_glitch", i), 32'(glitch0), 32'(vecs[i].exp_glitch));
    end
    clr0 = 1'b0;

    // Clear lands on the same edge as an accepted rise.
    gpio0 = 1'b1;
    tick(17);
    check("clracc_level_before", 32'(level0), 32'd0);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    check("clracc_level",  32'(level0),  32'd1);
    check("clracc_rise",   32'(rise0),   32'd1);
    check("clracc_edge",   32'(edge0),   32'd0);
    check("clracc_glitch", 32'(glitch0), 32'd0);
    tick(1);
    check("clracc_rise_off", 32'(rise0), 32'd0);

    // Narrow counters: 16 accepted toggles wrap, 20 glitches saturate.
    for (int i = 1; i <= 16; i++) begin
      gpio1 = ~gpio1;
      tick(8);
      if (i == 15) check("wrap_edge15", 32'(edge1), 32'd15);
    end
    check("wrap_edge0", 32'(edge1),  32'd0);
    check("wrap_level", 32'(level1), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      gpio1 = 1'b1;
      tick(2);
      gpio1 = 1'b0;
      tick(8);
      if (i == 15) check("sat_glitch15", 32'(glitch1), 32'd15);
    end
    check("sat_glitch20", 32'(glitch1), 32'd15);
    check("sat_edge",     32'(edge1),   32'd0);
    check("sat_level",    32'(level1),  32'd0);

    // Reset 8 cycles into a pending rise discards it without a glitch.
    gpio0 = 1'b0;
    tick(40);
    check("prerst_level", 32'(level0), 32'd0);
    check("prerst_edge",  32'(edge0),  32'd1);
    gpio0 = 1'b1;
    tick(10);
    rst = 1'b1;
    gpio0 = 1'b0;
    tick(1);
    check("midrst_level",  32'(level0),  32'd0);
    check("midrst_rise",   32'(rise0),   32'd0);
    check("midrst_edge",   32'(edge0),   32'd0);
    check("midrst_glitch", 32'(glitch0), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(25);
    check("postrst_glitch", 32'(glitch0), 32'd0);
    check("postrst_level",  32'(level0),  32'd0);
    check("postrst_edge",   32'(edge0),   32'd0);
    check("postrst_edge2",  32'(edge2),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rise0 && fall0) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_pulses: got rise=1 fall=1 expected at most one");
    end
  end

endmodule
